vx_tcu_fedp_seq: RTL and testbench

//  K-step sequencer for one TCU dot-product unit (VX_tcu_fedp_bhf/fp16/bf16 style, fixed LATENCY).

---
 rtl/vx_tcu_fedp_seq_if.sv | 39 +++
 rtl/vx_tcu_fedp_seq.sv | 82 ++++++++
 tb/tb_vx_tcu_fedp_seq.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/vx_tcu_fedp_seq_if.sv
// vx_tcu_fedp_seq_if: request/operand/response/unit bundle of the FEDP K-step sequencer; perf outputs under TCU_FEDP_SEQ_PERF_EN
interface vx_tcu_fedp_seq_if #(
  parameter int N = 1,
  parameter int XLEN = 32,
  parameter int STEPW = 8
);
  logic req_valid, req_ready;
  logic [2:0] req_fmt_s, req_fmt_d;
  logic [STEPW-1:0] req_steps;
  logic [XLEN-1:0] req_c;
  logic op_valid, op_ready;
  logic [N*XLEN-1:0] op_a, op_b;
  logic fedp_enable;
  logic [2:0] fedp_fmt_s, fedp_fmt_d;
  logic [N*XLEN-1:0] fedp_a_row, fedp_b_col;
  logic [XLEN-1:0] fedp_c_val, fedp_d_val;
  logic rsp_valid, rsp_ready;
  logic [XLEN-1:0] rsp_d;
  logic busy;
`ifdef TCU_FEDP_SEQ_PERF_EN
  logic [31:0] perf_busy_cycles, perf_steps, perf_stall_cycles;
`endif
  modport slave (
    input req_valid, req_fmt_s, req_fmt_d, req_steps, req_c, op_valid, op_a, op_b, fedp_d_val, rsp_ready,
    output req_ready, op_ready, fedp_enable, fedp_fmt_s, fedp_fmt_d, fedp_a_row, fedp_b_col, fedp_c_val,
    output rsp_valid, rsp_d, busy
`ifdef TCU_FEDP_SEQ_PERF_EN
    , output perf_busy_cycles, perf_steps, perf_stall_cycles
`endif
  );
  modport master (
    output req_valid, req_fmt_s, req_fmt_d, req_steps, req_c, op_valid, op_a, op_b, fedp_d_val, rsp_ready,
    input req_ready, op_ready, fedp_enable, fedp_fmt_s, fedp_fmt_d, fedp_a_row, fedp_b_col, fedp_c_val,
    input rsp_valid, rsp_d, busy
`ifdef TCU_FEDP_SEQ_PERF_EN
    , input perf_busy_cycles, perf_steps, perf_stall_cycles
`endif
  );
endinterface

// File: rtl/vx_tcu_fedp_seq.sv
// vx_tcu_fedp_seq: K-step sequencer chaining chunk dot products through a fixed-latency FEDP unit; perf counters under TCU_FEDP_SEQ_PERF_EN
module vx_tcu_fedp_seq #(
  parameter int N = 1,
  parameter int LATENCY = 10,
  parameter int STEPW = 8,
  parameter int XLEN = 32
) (
  input logic clk,
  input logic reset,
  vx_tcu_fedp_seq_if.slave bus
);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, WAIT = 2'd2, RESP = 2'd3;
  logic [1:0] state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [STEPW-1:0] steps_q, steps_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] fmt_s_q, fmt_s_d, fmt_d_q, fmt_d_d;
  logic accept, issue, capture;
  assign accept = bus.req_valid && bus.req_ready;
  assign issue = state_q == LOAD && bus.op_valid;
  assign capture = state_q == WAIT && cnt_q == '0;
  assign bus.req_ready = state_q == IDLE && !reset;
  assign bus.op_ready = state_q == LOAD;
  assign bus.fedp_enable = state_q != IDLE;
  assign bus.busy = state_q != IDLE;
  assign bus.fedp_fmt_s = fmt_s_q;
  assign bus.fedp_fmt_d = fmt_d_q;
  assign bus.fedp_a_row = issue ? bus.op_a : {N*XLEN{1'b0}};
  assign bus.fedp_b_col = issue ? bus.op_b : {N*XLEN{1'b0}};
  assign bus.fedp_c_val = acc_q;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_d = acc_q;
  // job accept, chunk issue, latency countdown and result capture
  always_comb begin
    state_d = accept ? (bus.req_steps == '0 ? RESP : LOAD)
            : issue ? WAIT
            : capture ? (steps_q == '0 ? RESP : LOAD)
            : (state_q == RESP && bus.rsp_ready) ? IDLE : state_q;
    acc_d = accept ? bus.req_c : capture ? bus.fedp_d_val : acc_q;
    steps_d = accept ? bus.req_steps : issue ? steps_q - STEPW'(1) : steps_q;
    cnt_d = issue ? CW'(LATENCY - 1) : state_q == WAIT ? cnt_q - CW'(1) : cnt_q;
    fmt_s_d = accept ? bus.req_fmt_s : fmt_s_q;
    fmt_d_d = accept ? bus.req_fmt_d : fmt_d_q;
  end
  // state registers; reset abandons any in-flight step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q <= '0;
      steps_q <= '0;
      cnt_q <= '0;
      fmt_s_q <= '0;
      fmt_d_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      steps_q <= steps_d;
      cnt_q <= cnt_d;
      fmt_s_q <= fmt_s_d;
      fmt_d_q <= fmt_d_d;
    end
  end
`ifdef TCU_FEDP_SEQ_PERF_EN
  logic [31:0] perf_busy_q, perf_steps_q, perf_stall_q;
  assign bus.perf_busy_cycles = perf_busy_q;
  assign bus.perf_steps = perf_steps_q;
  assign bus.perf_stall_cycles = perf_stall_q;
  // free-running wrap-around counters of busy cycles, issues and operand stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_busy_q <= '0;
      perf_steps_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_busy_q <= perf_busy_q + 32'(state_q != IDLE);
      perf_steps_q <= perf_steps_q + 32'(issue);
      perf_stall_q <= perf_stall_q + 32'(state_q == LOAD && !bus.op_valid);
    end
  end
`endif
endmodule

// File: tb/tb_vx_tcu_fedp_seq.sv
// tb_vx_tcu_fedp_seq: random jobs against a mock fixed-latency unit, checked with a chunk-sum reference
module tb_vx_tcu_fedp_seq;
  localparam int LAT = 10;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int exp_busy = 0, exp_steps = 0, exp_stall = 0;
  logic [31:0] pipe [LAT] = '{default: 32'h0};
  vx_tcu_fedp_seq_if #(.N(1), .XLEN(32), .STEPW(8)) bus ();
  vx_tcu_fedp_seq #(.N(1), .LATENCY(LAT), .STEPW(8), .XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // mock unit: d = c + (a ^ b), delivered LAT enabled cycles after presentation
  always @(posedge clk) begin
    if (bus.fedp_enable) begin
      pipe[0] <= bus.fedp_c_val + (bus.fedp_a_row ^ bus.fedp_b_col);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign bus.fedp_d_val = pipe[LAT-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_perf;
`ifdef TCU_FEDP_SEQ_PERF_EN
    check("perf_busy", bus.perf_busy_cycles, 32'(exp_busy));
    check("perf_steps", bus.perf_steps, 32'(exp_steps));
    check("perf_stall", bus.perf_stall_cycles, 32'(exp_stall));
`endif
  endtask

  task automatic run_job(input int steps, input logic [31:0] c, input int first_stall, input int max_stall, input int hold);
    logic [31:0] acc, a, b;
    logic [2:0] fs, fd;
    int k, next_ready, last_issue, issued, stall_left, stalls;
    bit done;
    acc = c;
    issued = 0;
    stalls = 0;
    last_issue = 0;
    next_ready = steps == 0 ? -1 : 1;
    done = 0;
    stall_left = first_stall;
    fs = $urandom_range(0, 2) == 0 ? 3'd1 : ($urandom_range(0, 1) == 0 ? 3'd2 : 3'd5);
    fd = 3'($urandom);
    bus.req_valid = 1'b1;
    bus.req_fmt_s = fs;
    bus.req_fmt_d = fd;
    bus.req_steps = 8'(steps);
    bus.req_c = c;
    bus.rsp_ready = 1'b0;
    bus.op_valid = 1'b0;
    #1;
    check("req_ready_idle", 32'(bus.req_ready), 1);
    tick;
    k = 1;
    while (!done && k < 3000) begin
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_steps = 8'($urandom);
      bus.req_c = $urandom;
      bus.rsp_ready = 1'b0;
      if (bus.op_ready) begin
        check("op_ready_cyc", 32'(k), 32'(next_ready));
        if (stall_left > 0) begin
          bus.op_valid = 1'b0;
          bus.op_a = $urandom;
          bus.op_b = $urandom;
          stall_left--;
          stalls++;
          next_ready = k + 1;
          #1;
          check("a_row_stall", bus.fedp_a_row, 0);
        end else begin
          a = $urandom;
          b = $urandom;
          bus.op_valid = 1'b1;
          bus.op_a = a;
          bus.op_b = b;
          #1;
          check("a_row", bus.fedp_a_row, a);
          check("b_col", bus.fedp_b_col, b);
          check("c_val", bus.fedp_c_val, acc);
          check("fmt_s", 32'(bus.fedp_fmt_s), 32'(fs));
          check("fmt_d", 32'(bus.fedp_fmt_d), 32'(fd));
          acc = acc + (a ^ b);
          issued++;
          last_issue = k;
          next_ready = k + LAT + 1;
          stall_left = $urandom_range(0, max_stall);
        end
      end else begin
        bus.op_valid = 1'($urandom_range(0, 1));
        bus.op_a = $urandom;
        bus.op_b = $urandom;
        #1;
        check("busy_job", {30'h0, bus.busy, bus.fedp_enable}, 32'h3);
        if (bus.rsp_valid) begin
          check("rsp_cyc", 32'(k), 32'(steps == 0 ? 1 : last_issue + LAT + 1));
          check("issued", 32'(issued), 32'(steps));
          check("rsp_d", bus.rsp_d, acc);
          check("req_ready_resp", 32'(bus.req_ready), 0);
          for (int h = 0; h < hold; h++) begin
            tick;
            bus.req_valid = 1'($urandom_range(0, 1));
            #1;
            check("rsp_hold", {31'h0, bus.rsp_valid}, 1);
            check("rsp_hold_d", bus.rsp_d, acc);
            check("req_ready_hold", 32'(bus.req_ready), 0);
          end
          tick;
          bus.req_valid = 1'b0;
          bus.rsp_ready = 1'b1;
          #1;
          check("rsp_accept_v", 32'(bus.rsp_valid), 1);
          tick;
          bus.rsp_ready = 1'b0;
          bus.op_valid = 1'b0;
          #1;
          check("idle_after", {29'h0, bus.req_ready, bus.busy, bus.rsp_valid}, 32'h4);
          exp_busy += k + hold + 1;
          exp_steps += steps;
          exp_stall += stalls;
          check_perf();
          done = 1;
        end else begin
          check("a_row_wait", bus.fedp_a_row, 0);
        end
      end
      if (!done) begin
        tick;
        k++;
      end
    end
    if (!done) check("job_timeout", 0, 1);
  endtask

  initial begin
    logic saw_rsp;
    bus.req_valid = 1'b0;
    bus.req_fmt_s = 3'd0;
    bus.req_fmt_d = 3'd0;
    bus.req_steps = 8'd0;
    bus.req_c = 32'h0;
    bus.op_valid = 1'b0;
    bus.op_a = 32'h0;
    bus.op_b = 32'h0;
    bus.rsp_ready = 1'b0;
    #1;
    check("rst_outs", {27'h0, bus.req_ready, bus.op_ready, bus.busy, bus.fedp_enable, bus.rsp_valid}, 0);
    check("rst_c_val", bus.fedp_c_val, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("req_ready_post_rst", 32'(bus.req_ready), 1);
    check("rsp_d_post_rst", bus.rsp_d, 0);
    check_perf();
    run_job(1, 32'h3F800000, 0, 0, 0);
    run_job(3, 32'h3F800000, 0, 0, 0);
    run_job(0, 32'hC0400000, 0, 0, 0);
    run_job(2, $urandom, 0, 0, 5);
    bus.req_valid = 1'b1;
    bus.req_steps = 8'd2;
    bus.req_c = $urandom;
    tick;
    bus.req_valid = 1'b0;
    bus.op_valid = 1'b1;
    bus.op_a = $urandom;
    bus.op_b = $urandom;
    tick;
    bus.op_valid = 1'b0;
    repeat (4) tick;
    reset = 1'b1;
    #1;
    check("rst_mid_outs", {27'h0, bus.req_ready, bus.op_ready, bus.busy, bus.fedp_enable, bus.rsp_valid}, 0);
    check("rst_mid_c", bus.fedp_c_val, 0);
    check("rst_mid_fmt", 32'(bus.fedp_fmt_s), 0);
    exp_busy = 0;
    exp_steps = 0;
    exp_stall = 0;
    tick;
    reset = 1'b0;
    #1;
    check("req_ready_rerst", 32'(bus.req_ready), 1);
    saw_rsp = 1'b0;
    repeat (3 * LAT) begin
      tick;
      saw_rsp |= bus.rsp_valid | bus.busy;
    end
    check("no_rsp_after_rst", 32'(saw_rsp), 0);
    check_perf();
    run_job(1, 32'h3F800000, 0, 0, 0);
    run_job(1, 32'h3F800000, 7, 0, 0);
    for (int j = 0; j < 10; j++)
      run_job($urandom_range(0, 5), $urandom, $urandom_range(0, 3), 3, $urandom_range(0, 3));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
